// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, used by both receive and transmit sides
// so the two ends always agree on frame format.
package uart_pkg;

    localparam int DATA_BITS      = 8;
    localparam int OVERSAMPLE_DEF = 16;

    // Receive/transmit bit-level states
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } uartState_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous control/serial lines. Resets to the
// line's idle level so nothing downstream sees a false edge out of reset.
module uart_sync2 #(
    parameter int         WIDTH     = 1,
    parameter logic [0:0] RESET_VAL = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] asyncIn,
    output logic [WIDTH-1:0] syncOut
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops to resolve metastability on the incoming line
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta    <= {WIDTH{RESET_VAL}};
            syncOut <= {WIDTH{RESET_VAL}};
        end else begin
            // NOTE: non-blocking assignments make the two stages shift in parallel;
            // blocking here would collapse the chain into a single flop.
            meta    <= asyncIn;
            syncOut <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 1 start / 8 data / 1 stop, no parity.
// Delivers each good byte on RxD_par with a one-cycle RxD_start strobe that
// can drive the transmit serializer directly for loopback/echo.
module uart_rx import uart_pkg::*; #(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,  // power of two, >= 8
    parameter int CNT_W      = 4                // log2(OVERSAMPLE)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 Baud16Tick,
    input  logic                 RxD_ser,
    output logic [DATA_BITS-1:0] RxD_par,
    output logic                 RxD_start,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int               BIT_W       = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] SAMPLE_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_BITS - 1);

    uartState_t           state;
    logic [CNT_W-1:0]     sampleCnt;
    logic [BIT_W-1:0]     bitCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 rxS;

    uart_sync2 #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .asyncIn   (RxD_ser),
        .syncOut   (rxS)
    );

    assign rx_busy = (state != S_IDLE);

    // Frame state machine, sample/bit counters, shift register and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            sampleCnt <= '0;
            bitCnt    <= '0;
            // NOTE: the shift register is reset along with the control state so a
            // reset mid-frame can never leak a partial byte into RxD_par.
            shiftReg  <= '0;
            RxD_par   <= '0;
            RxD_start <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Strobes default low; they are raised for exactly one cycle below.
            RxD_start <= 1'b0;
            frame_err <= 1'b0;

            if (Baud16Tick) begin
                case (state)
                    S_IDLE: begin
                        if (!rxS) begin
                            state     <= S_START;
                            sampleCnt <= '0;
                        end
                    end

                    S_START: begin
                        if (sampleCnt == SAMPLE_MID) begin
                            // Mid-start-bit sample: still low means a real start bit.
                            sampleCnt <= '0;
                            if (!rxS) begin
                                state  <= S_DATA;
                                bitCnt <= '0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            sampleCnt <= sampleCnt + 1'b1;
                        end
                    end

                    S_DATA: begin
                        if (sampleCnt == SAMPLE_LAST) begin
                            // LSB arrives first, so shift right and load at the top.
                            shiftReg  <= {rxS, shiftReg[DATA_BITS-1:1]};
                            sampleCnt <= '0;
                            bitCnt    <= bitCnt + 1'b1;
                            if (bitCnt == BIT_LAST) begin
                                state <= S_STOP;
                            end
                        end else begin
                            sampleCnt <= sampleCnt + 1'b1;
                        end
                    end

                    S_STOP: begin
                        if (sampleCnt == SAMPLE_LAST) begin
                            sampleCnt <= '0;
                            if (rxS) begin
                                RxD_par   <= shiftReg;
                                RxD_start <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                // Low stop bit: drop the byte and wait for the line
                                // to go idle so a held-low line cannot retrigger.
                                frame_err <= 1'b1;
                                state     <= S_BREAK;
                            end
                        end else begin
                            sampleCnt <= sampleCnt + 1'b1;
                        end
                    end

                    S_BREAK: begin
                        if (rxS) begin
                            state <= S_IDLE;
                        end
                    end

                    default: begin
                        state     <= S_IDLE;
                        sampleCnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: good frames, back-to-back frames,
// start glitch, framing error with held-low line, mid-frame reset, tick jitter.
module tb_uart_rx;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       Baud16Tick;
    logic       RxD_ser;
    logic [7:0] RxD_par;
    logic       RxD_start;
    logic       frame_err;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;

    // Tick generator state
    int gapCnt   = 0;
    int curGap   = 4;
    bit jitterOn = 0;
    int tickCount = 0;

    // Monitor state
    int         startCount = 0;
    int         errCount   = 0;
    int         overlap    = 0;
    int         busyCycles = 0;
    int         curW       = 0;
    int         lastW      = 0;
    logic [7:0] parQ[$];
    int         stampQ[$];

    uart_rx #(
        .OVERSAMPLE (16),
        .CNT_W      (4)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .Baud16Tick (Baud16Tick),
        .RxD_ser    (RxD_ser),
        .RxD_par    (RxD_par),
        .RxD_start  (RxD_start),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // One-cycle tick every curGap clocks, driven on the falling edge
    initial begin
        Baud16Tick = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (gapCnt >= curGap - 1) begin
                Baud16Tick = 1'b1;
                gapCnt     = 0;
                curGap     = jitterOn ? int'($urandom_range(7, 3)) : 4;
            end else begin
                Baud16Tick = 1'b0;
                gapCnt++;
            end
        end
    end

    always @(posedge sys_clk) begin
        if (Baud16Tick) tickCount++;
    end

    // Output monitor, sampled on the falling edge
    always @(negedge sys_clk) begin
        if (rx_busy) busyCycles++;
        if (RxD_start) begin
            if (curW == 0) begin
                startCount++;
                parQ.push_back(RxD_par);
                stampQ.push_back(tickCount);
            end
            curW++;
        end else begin
            if (curW != 0) lastW = curW;
            curW = 0;
        end
        if (frame_err) errCount++;
        if (RxD_start && frame_err) overlap++;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitTicks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge sys_clk);
            if (Baud16Tick) c++;
        end
    endtask

    task automatic sendBit(input logic b, input int n);
        @(negedge sys_clk);
        RxD_ser = b;
        waitTicks(n);
    endtask

    task automatic sendData(input logic [7:0] d);
        sendBit(1'b0, 16);
        for (int i = 0; i < 8; i++) sendBit(d[i], 16);
    endtask

    task automatic sendFrame(input logic [7:0] d);
        sendData(d);
        sendBit(1'b1, 16);
    endtask

    int busySnap;

    initial begin
        sys_rst_n = 1'b0;
        RxD_ser   = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Reset state
        check("rst_par",   32'(RxD_par),   'h00);
        check("rst_start", 32'(RxD_start), 'h0);
        check("rst_ferr",  32'(frame_err), 'h0);
        check("rst_busy",  32'(rx_busy),   'h0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Single byte 0x55
        sendBit(1'b1, 20);
        sendFrame(8'h55);
        sendBit(1'b1, 20);
        check("b55_count", 32'(startCount), 1);
        check("b55_par",   32'(RxD_par),    'h55);
        check("b55_ferr",  32'(errCount),   0);
        check("b55_width", 32'(lastW),      1);

        // Back-to-back 0xA3, 0x0F
        sendFrame(8'hA3);
        sendFrame(8'h0F);
        sendBit(1'b1, 20);
        check("b2b_count", 32'(startCount), 3);
        check("b2b_first", 32'(parQ[1]),    'hA3);
        check("b2b_second",32'(parQ[2]),    'h0F);
        check("b2b_gap",   32'(stampQ[2] - stampQ[1]), 160);
        check("b2b_par",   32'(RxD_par),    'h0F);

        // Start glitch: low for 4 ticks only
        busySnap = busyCycles;
        sendBit(1'b0, 4);
        sendBit(1'b1, 20);
        check("glitch_count", 32'(startCount), 3);
        check("glitch_ferr",  32'(errCount),   0);
        check("glitch_busy_seen", 32'(busyCycles > busySnap), 1);
        check("glitch_busy_max",  32'((busyCycles - busySnap) <= 8 * 4), 1);
        check("glitch_idle",  32'(rx_busy), 0);

        // Framing error: 0x3C with low stop bit, line held low 40 ticks
        sendData(8'h3C);
        sendBit(1'b0, 30);
        check("brk_ferr",  32'(errCount), 1);
        check("brk_busy",  32'(rx_busy),  1);
        check("brk_par",   32'(RxD_par),  'h0F);
        sendBit(1'b0, 10);
        check("brk_hold_busy", 32'(rx_busy), 1);
        sendBit(1'b1, 20);
        check("brk_ferr_once", 32'(errCount),   1);
        check("brk_nostart",   32'(startCount), 3);
        check("brk_par_kept",  32'(RxD_par),    'h0F);
        check("brk_idle",      32'(rx_busy),    0);

        // Reset during bit 4 of 0xFF
        sendBit(1'b0, 16);
        for (int i = 0; i < 4; i++) sendBit(1'b1, 16);
        sendBit(1'b1, 8);
        check("mid_busy", 32'(rx_busy), 1);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("mrst_par",   32'(RxD_par),   'h00);
        check("mrst_start", 32'(RxD_start), 'h0);
        check("mrst_ferr",  32'(frame_err), 'h0);
        check("mrst_busy",  32'(rx_busy),   'h0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        sendBit(1'b1, 20);
        check("mrst_nostart", 32'(startCount), 3);
        sendFrame(8'h81);
        sendBit(1'b1, 20);
        check("b81_count", 32'(startCount), 4);
        check("b81_par",   32'(RxD_par),    'h81);

        // Jittered ticks, 3..7 clocks apart
        jitterOn = 1'b1;
        sendBit(1'b1, 20);
        sendFrame(8'hC6);
        sendBit(1'b1, 20);
        check("jit_count", 32'(startCount), 5);
        check("jit_par",   32'(RxD_par),    'hC6);
        check("jit_width", 32'(lastW),      1);

        check("overlap",    32'(overlap),  0);
        check("ferr_total", 32'(errCount), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
